// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder, its checker and the test harness.
// Holds the checker state encoding and the default width/latency constants.
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REGS   = 4;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/pipelined_adder_checker_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside a data word.
// Shifts every cycle with no stall; clr empties it synchronously.
module operand_delay_line #(
  parameter int depth = 4,
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  output logic [width-1:0] out_data
);

  logic [depth-1:0]            valid_r;
  logic [depth-1:0][width-1:0] data_r;

  // Shift the stages, or empty them on reset/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      data_r  <= '0;
    end else if (clr) begin
      valid_r <= '0;
      data_r  <= '0;
    end else begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_data;
      for (int i = 1; i < depth; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[depth-1];
  assign out_data  = data_r[depth-1];

endmodule

// File: rtl/pipelined_adder_checker.sv
// Self-checking stage beside the pipelined adder: delays each operand pair by the
// adder latency, compares the true sum with outp, counts results, freezes the first mismatch.
module pipelined_adder_checker
  import pipelined_adder_pkg::*;
#(
  parameter int inp_data_width = DEF_DATA_WIDTH,
  parameter int num_regs       = DEF_NUM_REGS,
  parameter int cnt_width      = DEF_CNT_WIDTH,
  parameter bit stop_on_err    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      in_valid,
  input  logic [inp_data_width-1:0] inp1,
  input  logic [inp_data_width-1:0] inp2,
  input  logic [inp_data_width:0]   outp,
  output logic                      busy,
  output logic                      done,
  output logic                      err_flag,
  output logic [cnt_width-1:0]      pass_count,
  output logic [cnt_width-1:0]      err_count,
  output logic [inp_data_width:0]   first_err_exp,
  output logic [inp_data_width:0]   first_err_got
);

  localparam int DW  = 2 * inp_data_width;
  localparam int DCW = $clog2(num_regs + 1);

  state_t                    state_r, state_s;
  logic                      done_s;
  logic [DCW-1:0]            drain_cnt_r;
  logic                      busy_r, done_r, err_flag_r;
  logic [cnt_width-1:0]      pass_count_r, err_count_r;
  logic [inp_data_width:0]   first_err_exp_r, first_err_got_r;

  logic                      accept_s, clear_s;
  logic                      tail_valid_s;
  logic [DW-1:0]             tail_data_s;
  logic [inp_data_width:0]   exp_s;
  logic                      check_s, match_s, mismatch_s, halt_s, drain_last_s;

  // A pair sampled on the stop edge is not accepted; start only clears from IDLE/HALT.
  assign accept_s = (state_r == ST_RUN) && in_valid && !stop;
  assign clear_s  = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));

  operand_delay_line #(
    .depth (num_regs),
    .width (DW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clear_s),
    .in_valid  (accept_s),
    .in_data   ({inp1, inp2}),
    .out_valid (tail_valid_s),
    .out_data  (tail_data_s)
  );

  assign exp_s = {1'b0, tail_data_s[DW-1:inp_data_width]} + {1'b0, tail_data_s[inp_data_width-1:0]};
  assign check_s      = tail_valid_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  assign match_s      = check_s && (outp == exp_s);
  assign mismatch_s   = check_s && (outp != exp_s);
  assign halt_s       = mismatch_s && stop_on_err;
  assign drain_last_s = (drain_cnt_r == DCW'(num_regs - 1));

  // Next-state decode; a halting mismatch beats stop and the end of drain.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_s)    state_s = ST_HALT;
        else if (stop) state_s = ST_DRAIN;
        else           state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (halt_s) begin
          state_s = ST_HALT;
        end else if (drain_last_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_HALT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, drain timer and the registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_RUN)        drain_cnt_r <= '0;
      else if (state_r == ST_DRAIN) drain_cnt_r <= drain_cnt_r + DCW'(1);
      else                          drain_cnt_r <= drain_cnt_r;
      busy_r <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r <= done_s;
    end
  end

  // Result counters saturate; the first mismatch is captured only while err_flag is clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count_r    <= '0;
      err_count_r     <= '0;
      err_flag_r      <= 1'b0;
      first_err_exp_r <= '0;
      first_err_got_r <= '0;
    end else if (clear_s) begin
      pass_count_r    <= '0;
      err_count_r     <= '0;
      err_flag_r      <= 1'b0;
      first_err_exp_r <= '0;
      first_err_got_r <= '0;
    end else if (match_s) begin
      if (pass_count_r != {cnt_width{1'b1}}) pass_count_r <= pass_count_r + cnt_width'(1);
      else                                   pass_count_r <= pass_count_r;
    end else if (mismatch_s) begin
      if (err_count_r != {cnt_width{1'b1}}) err_count_r <= err_count_r + cnt_width'(1);
      else                                  err_count_r <= err_count_r;
      err_flag_r <= 1'b1;
      if (!err_flag_r) begin
        first_err_exp_r <= exp_s;
        first_err_got_r <= outp;
      end else begin
        first_err_exp_r <= first_err_exp_r;
        first_err_got_r <= first_err_got_r;
      end
    end else begin
      pass_count_r <= pass_count_r;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err_flag      = err_flag_r;
  assign pass_count    = pass_count_r;
  assign err_count     = err_count_r;
  assign first_err_exp = first_err_exp_r;
  assign first_err_got = first_err_got_r;

endmodule

// File: tb/tb_pipelined_adder_checker.sv
// Scoreboard bench: two checkers (halt-on-error/16-bit, keep-running/3-bit) share one
// emulated adder stream; a session-level model predicts every output after every edge.
module tb_pipelined_adder_checker;

  localparam int NR = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_HALT = 3;

  logic       clk, rst_n, start, stop, in_valid;
  logic [7:0] inp1, inp2;
  logic [8:0] outp;

  logic        busy0, done0, flag0, busy1, done1, flag1;
  logic [15:0] pass0, err0;
  logic [2:0]  pass1, err1;
  logic [8:0]  fexp0, fgot0, fexp1, fgot1;

  pipelined_adder_checker #(.inp_data_width(8), .num_regs(NR), .cnt_width(16), .stop_on_err(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .inp1(inp1), .inp2(inp2), .outp(outp), .busy(busy0), .done(done0), .err_flag(flag0),
    .pass_count(pass0), .err_count(err0), .first_err_exp(fexp0), .first_err_got(fgot0));

  pipelined_adder_checker #(.inp_data_width(8), .num_regs(NR), .cnt_width(3), .stop_on_err(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .inp1(inp1), .inp2(inp2), .outp(outp), .busy(busy1), .done(done1), .err_flag(flag1),
    .pass_count(pass1), .err_count(err1), .first_err_exp(fexp1), .first_err_got(fgot1));

  always #5 clk = ~clk;

  typedef struct { logic [8:0] e; logic [8:0] g; } pair_t;
  typedef struct { int due; logic [8:0] e; logic [8:0] g; logic [1:0] live; } infl_t;

  pair_t      pair_q[$];
  infl_t      infl[$];
  logic [8:0] adder_q[$];

  int n_chk = 0, n_fail = 0;
  int cmax[2] = '{65535, 7};
  int soe[2]  = '{1, 0};
  int ph[2], dleft[2], pc[2], ec[2], fe[2], fg[2];
  int fl[2], dn[2];
  int a_pass[2], a_err[2], a_flag[2], a_fe[2], a_fg[2], a_busy[2], a_done[2];

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus; also plays the adder, returning a+b+delta NR edges later.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input int delta, input logic st, input logic sp);
    logic [8:0] r;
    @(negedge clk);
    start = st; stop = sp; in_valid = v; inp1 = a; inp2 = b;
    if (v) r = {1'b0, a} + {1'b0, b} + 9'(delta);
    else   r = 9'($urandom);
    adder_q.push_back(r);
    if (adder_q.size() > NR) outp = adder_q.pop_front();
    if (v) pair_q.push_back('{e: {1'b0, a} + {1'b0, b}, g: r});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic flush(input int d);
    foreach (infl[i]) infl[i].live[d] = 1'b0;
  endtask

  task automatic clear_model(input int d);
    pc[d] = 0; ec[d] = 0; fl[d] = 0; fe[d] = 0; fg[d] = 0;
  endtask

  // Monitor: after each edge, advance the model with what the DUTs sampled and compare.
  int    cyc = 0;
  pair_t p;
  infl_t cur;
  logic  have_p, have_c, bad;
  logic [1:0] acc;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      have_p = 1'b0;
      if (in_valid && pair_q.size() > 0) begin
        p = pair_q.pop_front();
        have_p = 1'b1;
      end
      if (!rst_n) begin
        infl.delete();
        for (int d = 0; d < 2; d++) begin
          clear_model(d); ph[d] = P_IDLE; dn[d] = 0;
        end
      end else begin
        have_c = 1'b0;
        if (infl.size() > 0 && infl[0].due == cyc) begin
          cur = infl.pop_front();
          have_c = 1'b1;
        end
        acc = 2'b00;
        for (int d = 0; d < 2; d++) begin
          dn[d] = 0;
          if (ph[d] == P_IDLE || ph[d] == P_HALT) begin
            if (start) begin
              clear_model(d); flush(d); ph[d] = P_RUN;
            end
          end else begin
            bad = 1'b0;
            if (have_c && cur.live[d]) begin
              if (cur.e == cur.g) begin
                if (pc[d] < cmax[d]) pc[d]++;
              end else begin
                if (ec[d] < cmax[d]) ec[d]++;
                if (fl[d] == 0) begin fe[d] = int'(cur.e); fg[d] = int'(cur.g); end
                fl[d] = 1;
                bad = (soe[d] != 0);
              end
            end
            if (bad) begin
              ph[d] = P_HALT; flush(d);
            end else if (ph[d] == P_RUN) begin
              if (stop) begin ph[d] = P_DRAIN; dleft[d] = NR; end
              else if (have_p) acc[d] = 1'b1;
            end else begin
              dleft[d]--;
              if (dleft[d] == 0) begin ph[d] = P_IDLE; dn[d] = 1; end
            end
          end
        end
        if (acc != 2'b00) infl.push_back('{due: cyc + NR, e: p.e, g: p.g, live: acc});
      end
      a_pass[0] = int'(pass0); a_err[0] = int'(err0); a_flag[0] = int'(flag0);
      a_fe[0] = int'(fexp0); a_fg[0] = int'(fgot0); a_busy[0] = int'(busy0); a_done[0] = int'(done0);
      a_pass[1] = int'(pass1); a_err[1] = int'(err1); a_flag[1] = int'(flag1);
      a_fe[1] = int'(fexp1); a_fg[1] = int'(fgot1); a_busy[1] = int'(busy1); a_done[1] = int'(done1);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pass_count[%0d]", d), a_pass[d], pc[d]);
        chk($sformatf("err_count[%0d]", d), a_err[d], ec[d]);
        chk($sformatf("err_flag[%0d]", d), a_flag[d], fl[d]);
        chk($sformatf("first_err_exp[%0d]", d), a_fe[d], fe[d]);
        chk($sformatf("first_err_got[%0d]", d), a_fg[d], fg[d]);
        chk($sformatf("busy[%0d]", d), a_busy[d], (ph[d] == P_RUN || ph[d] == P_DRAIN) ? 1 : 0);
        chk($sformatf("done[%0d]", d), a_done[d], dn[d]);
      end
    end
  end

  logic [7:0] ta [10] = '{8'd0, 8'd255, 8'd255, 8'd1, 8'd128, 8'd17, 8'd200, 8'd99, 8'd3, 8'd64};
  logic [7:0] tb [10] = '{8'd0, 8'd1, 8'd255, 8'd2, 8'd128, 8'd34, 8'd55, 8'd1, 8'd250, 8'd64};

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    inp1 = 8'd0; inp2 = 8'd0; outp = 9'd0;
    idle(3);
    rst_n = 1'b1;
    drive(1'b1, 8'd5, 8'd6, 3, 1'b0, 1'b1);
    idle(6);

    // clean stream, including the 255+1 and 255+255 corners
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, ta[i], tb[i], 0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b1);
    idle(6);
    chk("clean_pass0", int'(pass0), 10);
    chk("clean_err0", int'(err0), 0);
    chk("sat_pass1", int'(pass1), 7);

    // bubbles with garbage outp in between
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 0, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b0);
    end
    drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b1);
    idle(6);
    chk("bubble_pass0", int'(pass0), 6);

    // injected error on the 3rd pair
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    drive(1'b1, 8'd10, 8'd20, 0, 1'b0, 1'b0);
    drive(1'b1, 8'd30, 8'd40, 0, 1'b0, 1'b0);
    drive(1'b1, 8'd100, 8'd27, -1, 1'b0, 1'b0);
    drive(1'b1, 8'd5, 8'd5, 0, 1'b0, 1'b0);
    drive(1'b1, 8'd6, 8'd6, 0, 1'b0, 1'b0);
    idle(6);
    drive(1'b1, 8'd7, 8'd7, 0, 1'b0, 1'b1);
    drive(1'b1, 8'd8, 8'd8, 0, 1'b0, 1'b0);
    idle(6);
    chk("halt_exp0", int'(fexp0), 127);
    chk("halt_got0", int'(fgot0), 126);
    chk("halt_pass0", int'(pass0), 2);
    chk("halt_busy0", int'(busy0), 0);

    // errors on 2nd and 5th of 8 pairs; dut1 keeps counting
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 8'(50 + i), 8'(60 + i), (i == 1) ? 3 : ((i == 4) ? -2 : 0), 1'b0, 1'b0);
    drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b1);
    idle(6);
    chk("multi_err1", int'(err1), 2);
    chk("multi_pass1", int'(pass1), 6);
    chk("multi_exp1", int'(fexp1), 112);
    chk("multi_got1", int'(fgot1), 115);

    // mismatch checked on the same edge as stop
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    drive(1'b1, 8'd9, 8'd9, 1, 1'b0, 1'b0);
    for (int i = 0; i < NR - 1; i++) drive(1'b1, 8'd1, 8'd1, 0, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 8'd2, 0, 1'b0, 1'b1);
    idle(6);
    chk("stopcoll_err0", int'(err0), 1);

    // randomized sessions
    for (int r = 0; r < 4; r++) begin
      drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++)
        drive(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 11) == 0) ? 1 : 0,
              1'($urandom_range(0, 9) == 0), 1'b0);
      drive(1'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);
      idle(6);
    end

    // asynchronous reset with pairs in flight
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i), 8'(i), 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy0", int'(busy0), 0);
    chk("arst_pass0", int'(pass0), 0);
    chk("arst_pass1", int'(pass1), 0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    drive(1'b0, 8'd0, 8'd0, 0, 1'b1, 1'b0);
    drive(1'b1, 8'd11, 8'd22, 0, 1'b0, 1'b0);
    drive(1'b1, 8'd33, 8'd44, 0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 8'd0, 0, 1'b0, 1'b1);
    idle(6);
    chk("post_rst_pass0", int'(pass0), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_checker.md
Name: pipelined_adder_checker

Overview:
Downstream self-checking stage for the pipelined adder. Captures each operand pair as it enters the adder and delays it by the adder latency. Compares the true sum against the adder's `outp` on the matching cycle, then counts passes and errors and freezes the first mismatch. Sits beside the adder in the pipelined-adder test harness; the testbench and simulation display read its results.

Parameters:
- inp_data_width, 8, operand width; result width is inp_data_width+1.
- num_regs, 4, adder latency in cycles; must be at least 1.
- cnt_width, 16, width of pass/error counters.
- stop_on_err, 1, 1 = enter HALT on first mismatch; 0 = keep running and counting.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse; clears results and begins checking.
- stop, in, 1, single-cycle pulse; stops accepting operands and drains in-flight pairs.
- in_valid, in, 1, the operand pair on inp1/inp2 enters the adder this cycle.
- inp1, in, inp_data_width, operand 1 as applied to the adder.
- inp2, in, inp_data_width, operand 2 as applied to the adder.
- outp, in, inp_data_width+1, adder result.
- busy, out, 1, high in RUN or DRAIN.
- done, out, 1, one-cycle pulse on DRAIN->IDLE.
- err_flag, out, 1, sticky: at least one mismatch since last start.
- pass_count, out, cnt_width, number of matching results.
- err_count, out, cnt_width, number of mismatching results.
- first_err_exp, out, inp_data_width+1, expected sum of the first mismatch.
- first_err_got, out, inp_data_width+1, outp value of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; delay line valid bits cleared.
  - Reset mid-operation discards in-flight pairs; no done pulse.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE:
  - in_valid ignored.
  - start -> RUN; on that edge clear counters, err_flag, first_err_* and the delay line.
  - stop in IDLE is ignored.
- RUN:
  - A pair with in_valid=1 sampled at edge k is checked against outp sampled at edge k+num_regs.
  - Counters and err_flag reflect that check immediately after edge k+num_regs.
  - in_valid=0 cycles insert bubbles; a bubble never counts as a pass or an error.
  - start is ignored.
  - stop -> DRAIN. The pair (if any) sampled on the stop edge is NOT accepted.
- DRAIN:
  - No new pairs accepted.
  - Stays exactly num_regs cycles so every accepted pair is checked.
  - Then -> IDLE, done=1 for one cycle.
- Expected sum: zero-extended inp1 + inp2 at inp_data_width+1 bits; no overflow is possible (255+255=510 for width 8).
- Match:
  - pass_count += 1, saturating at all-ones.
- Mismatch:
  - err_count += 1, saturating.
  - err_flag set.
  - first_err_exp/got captured only if err_flag was 0.
  - If stop_on_err=1: -> HALT from RUN or DRAIN. In-flight pairs are discarded unchecked.
- HALT:
  - Counters and capture frozen; busy=0.
  - start -> RUN with a full clear, same as from IDLE.
- Simultaneous events:
  - Mismatch and stop on the same edge: HALT wins when stop_on_err=1.
  - Mismatch on the final DRAIN cycle with stop_on_err=1: HALT, no done.
- Delay line: num_regs stages of {valid, inp1, inp2}, shifted every cycle. Never stalls; the adder pipeline has no backpressure.

Decomposition:
- Shared package pipelined_adder_pkg holds:
  - the state encoding (IDLE=0, RUN=1, DRAIN=2, HALT=3);
  - default width/latency constants shared with the adder and the harness.
- One natural sub-module: operand_delay_line, a parameterised depth/width shift register with a valid bit and async active-low clear. The adder harness can reuse it.

Test Plan:
- Clean stream, num_regs=4: start, then 10 back-to-back pairs (0+0 .. 255+1 -> 256, 255+255 -> 510), correct outp, then stop -> pass_count=10, err_count=0, done pulses exactly 4 cycles after the stop edge.
- Bubbles: 6 pairs alternating with in_valid=0 cycles -> pass_count=6; outp garbage during bubbles causes no errors.
- Injected error, stop_on_err=1: 3rd pair 100+27 but outp=126 -> err_flag=1, err_count=1, first_err_exp=127, first_err_got=126, state HALT, pass_count=2; later pairs ignored until start.
- stop_on_err=0: 8 pairs, errors on 2nd and 5th -> err_count=2, pass_count=6, first_err_* holds the 2nd pair's values.
- Saturation, cnt_width=3: 10 correct pairs -> pass_count=7, holds at 7.
- Reset mid-run: rst_n low while 3 pairs in flight -> all outputs 0 asynchronously, IDLE, no done; after release a new start counts from 0.
